// File: rtl/vmsm_vend_ctrl.sv
// Vending machine credit/dispense sequencer: coin credit, price check, dispense hand-off, unit-wise change.
// Optional idle auto-refund in CREDIT is enabled by defining VMSM_TIMEOUT_EN.
module vmsm_vend_ctrl #(
    parameter int CREDIT_W    = 8,
    parameter int CREDIT_MAX  = 200,
    parameter int PRICE0      = 12,
    parameter int PRICE1      = 15,
    parameter int PRICE2      = 20,
    parameter int PRICE3      = 30,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                coin_valid,
    input  logic [3:0]          coin_units,
    input  logic                sel_valid,
    input  logic [1:0]          sel_id,
    input  logic                cancel,
    output logic                disp_req,
    output logic [1:0]          disp_id,
    input  logic                disp_done,
    output logic                chg_req,
    input  logic                chg_ack,
    output logic                coin_reject,
    output logic                sel_short,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_DISPENSE,
        ST_CHANGE
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [CREDIT_W-1:0] r_credit,   w_credit_nxt;
    logic                r_disp_req, w_disp_req_nxt;
    logic [1:0]          r_disp_id,  w_disp_id_nxt;
    logic                r_reject,   w_reject_nxt;
    logic                r_short,    w_short_nxt;

    logic [CREDIT_W:0]   w_sum;
    logic                w_coin_ok;
    logic [CREDIT_W-1:0] w_base;
    logic [CREDIT_W-1:0] w_price;
    logic                w_tmo_hit;

    // One extra bit on the sum so an overflowing coin is caught by the ceiling compare.
    assign w_sum     = {1'b0, r_credit} + (CREDIT_W+1)'(coin_units);
    assign w_coin_ok = coin_valid && (coin_units != 4'd0)
                       && (w_sum <= (CREDIT_W+1)'(CREDIT_MAX))
                       && (r_state == ST_IDLE || r_state == ST_CREDIT);
    assign w_base    = w_coin_ok ? w_sum[CREDIT_W-1:0] : r_credit;

    always_comb begin
        case (sel_id)
            2'd0:    w_price = CREDIT_W'(PRICE0);
            2'd1:    w_price = CREDIT_W'(PRICE1);
            2'd2:    w_price = CREDIT_W'(PRICE2);
            default: w_price = CREDIT_W'(PRICE3);
        endcase
    end

`ifdef VMSM_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state != ST_CREDIT || w_state_nxt != r_state || w_coin_ok || sel_valid) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    // NOTE: every next-value gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt    = r_state;
        w_credit_nxt   = r_credit;
        w_disp_req_nxt = r_disp_req;
        w_disp_id_nxt  = r_disp_id;
        w_reject_nxt   = coin_valid && !w_coin_ok;
        w_short_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_coin_ok) begin
                    w_credit_nxt = w_base;
                    w_state_nxt  = ST_CREDIT;
                end
                w_short_nxt = sel_valid;
            end
            ST_CREDIT: begin
                w_credit_nxt = w_base;
                if (cancel) begin
                    w_state_nxt = ST_CHANGE;
                end else if (sel_valid) begin
                    // Affordability uses pre-coin credit; a same-cycle coin is still banked.
                    if (r_credit >= w_price) begin
                        w_credit_nxt   = w_base - w_price;
                        w_disp_req_nxt = 1'b1;
                        w_disp_id_nxt  = sel_id;
                        w_state_nxt    = ST_DISPENSE;
                    end else begin
                        w_short_nxt = 1'b1;
                    end
                end else if (w_tmo_hit && !w_coin_ok) begin
                    w_state_nxt = ST_CHANGE;
                end
            end
            ST_DISPENSE: begin
                if (disp_done) begin
                    w_disp_req_nxt = 1'b0;
                    w_state_nxt    = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            default: begin
                if (r_credit == '0) begin
                    w_state_nxt = ST_IDLE;
                end else if (chg_ack) begin
                    w_credit_nxt = r_credit - 1'b1;
                    if (r_credit == CREDIT_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_credit   <= '0;
            r_disp_req <= 1'b0;
            r_disp_id  <= 2'd0;
            r_reject   <= 1'b0;
            r_short    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_credit   <= w_credit_nxt;
            r_disp_req <= w_disp_req_nxt;
            r_disp_id  <= w_disp_id_nxt;
            r_reject   <= w_reject_nxt;
            r_short    <= w_short_nxt;
        end
    end

    assign disp_req    = r_disp_req;
    assign disp_id     = r_disp_id;
    assign chg_req     = (r_state == ST_CHANGE) && (r_credit != '0);
    assign coin_reject = r_reject;
    assign sel_short   = r_short;
    assign credit      = r_credit;
    assign busy        = (r_state == ST_DISPENSE) || (r_state == ST_CHANGE);

endmodule
